booth_mul_seq: RTL and testbench

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_mul_seq.sv | 172 +++++++++++++++++
 tb/tb_booth_mul_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one recoded digit per cycle, signed or unsigned operands.
// Optional early termination when the remaining multiplier digits are all zero: BOOTH_MUL_EARLY_EXIT_EN.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [EW-1:0]      a_r, mult_r, mult_s;
  logic [AW-1:0]      acc_r, acc_s, addend_s, operand_s, sum_s;
  logic               lb_r, lb_s;
  logic [CW-1:0]      cnt_r;
  logic [2:0]         dig_s;
  logic               run_s, last_s, finish_s, accept_s;
  logic [2*WIDTH-1:0] z_s;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
  logic               signed_r;
  logic [EW-1:0]      rem_r, rem_s;
  logic [CW-1:0]      shamt_s;
  logic               exit_s;
`endif

  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  // Recoded digit flags {nonzero, double, negate} from {b[1], b[0], look-back}
  function automatic logic [2:0] booth_digit(input logic [2:0] trip);
    logic [2:0] d;
    case (trip)
      3'b000, 3'b111: d = 3'b000;
      3'b001, 3'b010: d = 3'b100;
      3'b011:         d = 3'b110;
      3'b100:         d = 3'b111;
      3'b101, 3'b110: d = 3'b101;
      default:        d = 3'b000;
    endcase
    return d;
  endfunction

  assign run_s    = (state_r == RUN);
  assign accept_s = start && (state_r != RUN);

  // One Booth iteration: single adder, then arithmetic shift of {acc, mult, look-back} by two
  always_comb begin
    dig_s = booth_digit({mult_r[1:0], lb_r});
    if (!dig_s[2]) begin
      addend_s = {AW{1'b0}};
    end else if (dig_s[1]) begin
      addend_s = {a_r, 1'b0};
    end else begin
      addend_s = {a_r[EW-1], a_r};
    end
    if (dig_s[0]) begin
      operand_s = ~addend_s;
    end else begin
      operand_s = addend_s;
    end
    sum_s  = acc_r + operand_s + {{(AW-1){1'b0}}, dig_s[0]};
    acc_s  = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    mult_s = {sum_s[1:0], mult_r[EW-1:2]};
    lb_s   = mult_r[1];
    last_s = (cnt_r == CW'(N - 1));
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    // rem tracks the untouched multiplier bits; its sign fill mirrors the extended operand
    rem_s   = {{2{rem_r[EW-1]}}, rem_r[EW-1:2]};
    exit_s  = ((rem_s == {EW{1'b0}}) && !lb_s) ||
              (signed_r && (rem_s == {EW{1'b1}}) && lb_s);
    shamt_s = CW'(N - 1) - cnt_r;
    // Skipped iterations would only shift: apply all of them at once
    z_s      = (2*WIDTH)'($signed({acc_s, mult_s}) >>> {shamt_s, 1'b0});
    finish_s = last_s || exit_s;
`else
    z_s      = {acc_s[WIDTH-3:0], mult_s};
    finish_s = last_s;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (finish_s) state_s = DONE;
        else          state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= {EW{1'b0}};
      mult_r   <= {EW{1'b0}};
      acc_r    <= {AW{1'b0}};
      lb_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
`ifdef BOOTH_MUL_EARLY_EXIT_EN
      signed_r <= 1'b0;
      rem_r    <= {EW{1'b0}};
`endif
    end else if (accept_s) begin
      a_r      <= extend(a, is_signed);
      mult_r   <= extend(b, is_signed);
      acc_r    <= {AW{1'b0}};
      lb_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
`ifdef BOOTH_MUL_EARLY_EXIT_EN
      signed_r <= is_signed;
      rem_r    <= extend(b, is_signed);
`endif
    end else if (run_s) begin
      acc_r    <= acc_s;
      mult_r   <= mult_s;
      lb_r     <= lb_s;
      cnt_r    <= cnt_r + CW'(1);
`ifdef BOOTH_MUL_EARLY_EXIT_EN
      rem_r    <= rem_s;
`endif
    end
  end

  // Registered status and result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      z    <= {(2*WIDTH){1'b0}};
    end else begin
      busy <= (state_s == RUN);
      done <= run_s && finish_s;
      if (run_s && finish_s) begin
        z <= z_s;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: driver pushes expected product and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_booth_mul_seq;

  localparam int W = 32;
  localparam int N = W / 2 + 1;

  logic           clk = 1'b0;
  logic           rst_n, start, is_signed;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] z;

  typedef struct {
    logic [2*W-1:0] z;
    longint         cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint cyc     = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .z(z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    sx = sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    sy = sgn ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return sx * sy;
  endfunction

  // Iterations expected before done: fixed, or first point where the rest of b is inert
  function automatic longint exp_lat(input logic sgn, input logic [W-1:0] bv);
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    logic [W+1:0] be, rest, ones;
    be = {{2{sgn & bv[W-1]}}, bv};
    for (int m = 1; m <= N; m++) begin
      rest = be >> (2 * m - 1);
      ones = ({{(W+1){1'b0}}, 1'b1} << (W + 3 - 2 * m)) - {{(W+1){1'b0}}, 1'b1};
      if (rest == {(W+2){1'b0}}) return m;
      if (sgn && rest == ones) return m;
    end
    return N;
`else
    return N;
`endif
  endfunction

  task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; start is accepted at the following posedge
  task automatic drive(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] ez);
    exp_t e;
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    e.z   = ez;
    e.cyc = cyc + 1 + exp_lat(sgn, bv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
    drive(sgn, av, bv, ref_mul(sgn, av, bv));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: no done within %0d cycles", 4 * N);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_spurious: done=1 with nothing pending, z=%h", z);
      end else begin
        mon_e = sb.pop_front();
        check("product", z, mon_e.z);
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic           sgn;
    logic [W-1:0]   av, bv;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_z", z, 64'd0);

    // First start accepted at the first edge with rst_n high
    rst_n = 1'b1;
    drive(1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done();
    // Back-to-back directed corners, each issued in the DONE cycle
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_done();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done();
    drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    wait_done();
    drive(1'b0, 32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F);
    wait_done();
    drive(1'b1, 32'h0000_3039, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7);
    wait_done();
    repeat (2) @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // start during RUN with other operands must be ignored
    issue(1'b0, 32'h1234_5678, 32'h8000_0001);
    repeat (4) @(negedge clk);
    start = 1'b1; is_signed = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(1'b1, 32'hCAFE_BABE, 32'h8765_4321);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done();

    // Reset in cycle 8 of RUN, with a coincident start that must be ignored
    repeat (2) @(negedge clk);
    issue(1'b1, 32'h0F0F_0F0F, 32'h8000_0001);
    repeat (7) @(negedge clk);
    sb.delete();
    rst_n = 1'b0; start = 1'b1; a = 32'h0000_0011; b = 32'h8000_0003; is_signed = 1'b0;
    @(negedge clk);
    check("midrun_reset_busy", {63'd0, busy}, 64'd0);
    check("midrun_reset_done", {63'd0, done}, 64'd0);
    check("midrun_reset_z", z, 64'd0);
    rst_n = 1'b1;
    issue(1'b0, 32'h9ABC_DEF0, 32'h1357_9BDF);
    wait_done();

    // Randomized operands with biased corners, mixed back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      av  = $urandom;
      bv  = $urandom;
      case ($urandom_range(0, 5))
        0: av = 32'h8000_0000;
        1: bv = 32'hFFFF_FFFF;
        2: bv = 32'($urandom_range(0, 15));
        3: av = 32'h0000_0000;
        4: bv = 32'h8000_0000;
        default: ;
      endcase
      issue(sgn, av, bv);
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
